// File: rtl/load_store_unit.sv
// load_store_unit
//   RV32I load/store unit between a core request port and a single-word
//   memory port. It accepts one request at a time, checks alignment and
//   funct3, drives one memory access with byte-lane enables, and returns a
//   one-cycle response with the extended load data or an error.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid/req_ready    request handshake (see below)
//   req_we, funct3         1=store/0=load; RV32I width/sign encoding
//   addr, wdata            byte address, right-aligned store data
//   resp_valid, rdata, err one-cycle response; rdata/err are 0 otherwise
//   mem_req, mem_we        memory request and write enable, held until ack/timeout
//   mem_be, mem_addr       byte-lane enables, word-aligned address
//   mem_wdata              store data replicated into every lane
//   mem_ack, mem_rdata     memory completion and read word
//   state_dbg              current FSM state (IDLE=0, ACCESS=1, RESP=2)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is high only in IDLE and outside reset;
// the core keeps req_valid and the request fields stable until it transfers.
// On the memory side mem_req and its qualifiers stay constant until an edge
// with mem_ack=1, or until the wait counter expires.
module load_store_unit #(
  parameter int N       = 32,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  output logic         resp_valid,
  output logic [N-1:0] rdata,
  output logic         err,
  output logic         mem_req,
  output logic         mem_we,
  output logic [3:0]   mem_be,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t       state;
  logic         req_we_q;
  logic [2:0]   funct3_q;
  logic [N-1:0] addr_q;
  logic [N-1:0] wdata_q;
  logic [7:0]   wait_cnt;
  logic [N-1:0] rdata_q;
  logic         err_q;

  // Incoming request checks, evaluated in IDLE before anything is registered.
  logic req_legal;
  logic req_misaligned;

  always_comb begin
    req_legal = 1'b0;
    if (req_we) begin
      req_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      req_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    req_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  // Memory-side view of the registered request. funct3[1:0] is the access
  // size (00 byte, 01 half, 10 word); the sign bit funct3[2] does not matter here.
  logic [3:0]   be_q;
  logic [N-1:0] wdata_rep_q;

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        be_q        = 4'b0001 << addr_q[1:0];
        wdata_rep_q = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_q        = 4'b0011 << addr_q[1:0];
        wdata_rep_q = {2{wdata_q[15:0]}};
      end
      default: begin
        be_q        = 4'b1111;
        wdata_rep_q = wdata_q;
      end
    endcase
  end

  // Load result: shift the addressed lane down to bit 0, then extend.
  logic [N-1:0] lane;
  logic [N-1:0] load_val;

  always_comb begin
    lane = mem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{(N-8){lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{(N-16){lane[15]}}, lane[15:0]};
      3'b100:  load_val = {{(N-8){1'b0}}, lane[7:0]};
      3'b101:  load_val = {{(N-16){1'b0}}, lane[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_we_q <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_cnt <= 8'd0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          if (req_valid) begin
            req_we_q <= req_we;
            funct3_q <= funct3;
            addr_q   <= addr;
            wdata_q  <= wdata;
            wait_cnt <= 8'd0;
            if (!req_legal || req_misaligned) begin
              // Rejected before reaching memory: straight to the response.
              err_q <= 1'b1;
              state <= RESP;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // An ack in the same cycle the counter expires still completes normally.
          if (mem_ack) begin
            rdata_q <= req_we_q ? '0 : load_val;
            err_q   <= 1'b0;
            state   <= RESP;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are flop values gated by the registered state, so they are
  // glitch-free and read 0 whenever their qualifying state is not active.
  always_comb begin
    req_ready  = (state == IDLE) && rst_n;
    resp_valid = (state == RESP);
    rdata      = resp_valid ? rdata_q : '0;
    err        = resp_valid ? err_q : 1'b0;
    mem_req    = (state == ACCESS);
    mem_we     = mem_req ? req_we_q : 1'b0;
    mem_be     = mem_req ? be_q : 4'b0000;
    mem_addr   = mem_req ? {addr_q[N-1:2], 2'b00} : '0;
    mem_wdata  = mem_req ? wdata_rep_q : '0;
    state_dbg  = state;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit, built with TIMEOUT=4.
// Inputs change and outputs are sampled on the falling clock edge.
// Latency counting: the acceptance cycle is cycle 1, so a zero-wait access
// shows resp_valid two edges after acceptance (cycle 3) and an error
// response one edge after acceptance (cycle 2).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit #(.N(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .err        (err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .state_dbg  (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          delay;      // idle ACCESS cycles before mem_ack
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    req_we    = 1'b0;
    funct3    = 3'b000;
    addr      = '0;
    wdata     = '0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h5A5A_5A5A;
  endtask

  // Drive one request; returns after the acceptance edge, at the next negedge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input string tag);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic run_vec(input int k);
    vec_t  v;
    string t;
    v = vecs[k];
    t = $sformatf("v%0d", k);
    issue(v.we, v.f3, v.addr, v.wdata, t);
    if (v.exp_err) begin
      check({t, " resp_valid"}, 32'(resp_valid), 32'd1);
      check({t, " err"}, 32'(err), 32'd1);
      check({t, " rdata"}, rdata, 32'd0);
      check({t, " mem_req"}, 32'(mem_req), 32'd0);
    end else begin
      for (int c = 0; c <= v.delay; c++) begin
        check({t, " mem_req"}, 32'(mem_req), 32'd1);
        check({t, " mem_we"}, 32'(mem_we), 32'(v.we));
        check({t, " mem_be"}, 32'(mem_be), 32'(v.exp_be));
        check({t, " mem_addr"}, mem_addr, v.exp_maddr);
        check({t, " mem_wdata"}, mem_wdata, v.exp_mwdata);
        check({t, " early resp_valid"}, 32'(resp_valid), 32'd0);
        if (c == v.delay) begin
          mem_ack   = 1'b1;
          mem_rdata = v.mrdata;
        end
        @(negedge clk);
      end
      idle_inputs();
      check({t, " resp_valid"}, 32'(resp_valid), 32'd1);
      check({t, " err"}, 32'(err), 32'd0);
      check({t, " rdata"}, rdata, v.exp_rdata);
      check({t, " mem_req after ack"}, 32'(mem_req), 32'd0);
    end
    @(negedge clk);
    check({t, " resp_valid one cycle"}, 32'(resp_valid), 32'd0);
    check({t, " rdata idle"}, rdata, 32'd0);
    check({t, " err idle"}, 32'(err), 32'd0);
    check({t, " req_ready back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    // we  f3      addr          wdata         mrdata        dly err be       maddr         mwdata        rdata
    vecs[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_FF12, 0, 1'b0, 4'b1000, 32'h0000_1000, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'hABCD_1234, 1, 1'b0, 4'b1100, 32'h0000_2000, 32'h0,        32'h0000_ABCD};
    vecs[2]  = '{1'b1, 3'b000, 32'h0000_0011, 32'h1234_5678, 32'hDEAD_BEEF, 0, 1'b0, 4'b0010, 32'h0000_0010, 32'h7878_7878, 32'h0};
    vecs[3]  = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0};
    // ack lands in the same cycle the counter expires: completes normally
    vecs[4]  = '{1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 3, 1'b0, 4'b1100, 32'h0000_0000, 32'h0,        32'hFFFF_8001};
    vecs[5]  = '{1'b0, 3'b100, 32'h0000_0001, 32'h0,        32'h0000_F000, 2, 1'b0, 4'b0010, 32'h0000_0000, 32'h0,        32'h0000_00F0};
    vecs[6]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hCAFE_F00D, 0, 1'b0, 4'b1111, 32'h0000_0100, 32'h0,        32'hCAFE_F00D};
    vecs[7]  = '{1'b1, 3'b001, 32'h0000_0022, 32'hAAAA_BEEF, 32'h1111_1111, 1, 1'b0, 4'b1100, 32'h0000_0020, 32'hBEEF_BEEF, 32'h0};
    vecs[8]  = '{1'b1, 3'b010, 32'h0000_0030, 32'h0102_0304, 32'h0,        0, 1'b0, 4'b1111, 32'h0000_0030, 32'h0102_0304, 32'h0};
    vecs[9]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[10] = '{1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[11] = '{1'b1, 3'b001, 32'h0000_0003, 32'hFFFF,     32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[12] = '{1'b0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_007F, 0, 1'b0, 4'b0001, 32'h0000_0000, 32'h0,        32'h0000_007F};

    // Reset
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst mem_be", 32'(mem_be), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post-rst req_ready", 32'(req_ready), 32'd1);

    // Table of single transactions
    for (int k = 0; k < NV; k++) run_vec(k);

    // SW with no ack: mem_req for exactly TIMEOUT=4 cycles, then error response,
    // and a late ack raises no second response.
    issue(1'b1, 3'b010, 32'h0000_0040, 32'h0000_0055, "tmo");
    for (int c = 0; c < 4; c++) begin
      check($sformatf("tmo mem_req c%0d", c), 32'(mem_req), 32'd1);
      check($sformatf("tmo mem_wdata c%0d", c), mem_wdata, 32'h0000_0055);
      check($sformatf("tmo resp_valid c%0d", c), 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    check("tmo resp_valid", 32'(resp_valid), 32'd1);
    check("tmo err", 32'(err), 32'd1);
    check("tmo rdata", rdata, 32'd0);
    check("tmo mem_req dropped", 32'(mem_req), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("tmo late ack resp c%0d", c), 32'(resp_valid), 32'd0);
      check($sformatf("tmo late ack mem_req c%0d", c), 32'(mem_req), 32'd0);
    end
    idle_inputs();

    // Reset in the middle of an access: no response for the aborted request.
    issue(1'b0, 3'b010, 32'h0000_0080, 32'h0, "rstacc");
    check("rstacc mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstacc mem_req after", 32'(mem_req), 32'd0);
    check("rstacc resp_valid after", 32'(resp_valid), 32'd0);
    check("rstacc req_ready in rst", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rstacc req_ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rstacc no resp c%0d", c), 32'(resp_valid), 32'd0);
    end

    // Unit still works after the aborted access.
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter N, default 32, data and address width; only N=32 is supported.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum mem_ack wait in cycles, range 1..255.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have port req_valid, input, 1, core issues a load/store.
REQ-006 SHALL have port req_ready, output, 1, unit accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1, 1=store, 0=load.
REQ-008 SHALL have port funct3, input, 3, RV32I width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
REQ-009 SHALL have port addr, input, N, byte address.
REQ-010 SHALL have port wdata, input, N, store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port rdata, output, N, load result, extended; 0 for stores and errors.
REQ-013 SHALL have port err, output, 1, qualifies resp_valid: misaligned, illegal funct3, or timeout.
REQ-014 SHALL have port mem_req, output, 1, memory access request, held until ack or timeout.
REQ-015 SHALL have port mem_we, output, 1, memory write enable.
REQ-016 SHALL have port mem_be, output, 4, byte-lane enables.
REQ-017 SHALL have port mem_addr, output, N, word address, with addr[1:0] forced to 00.
REQ-018 SHALL have port mem_wdata, output, N, store data replicated into the selected lanes.
REQ-019 SHALL have port mem_ack, input, 1, memory completes access this cycle.
REQ-020 SHALL have port mem_rdata, input, N, read word, valid when mem_ack=1.

Function
REQ-021 SHALL implement states IDLE, ACCESS, RESP.
REQ-022 SHALL drive req_ready=1 only in IDLE.
REQ-023 SHALL, in IDLE on req_valid=1, register req_we, funct3, addr and wdata.
REQ-024 SHALL, on such a request, go to RESP with err=1 if the request is misaligned (half with addr[0]=1, word with addr[1:0]!=00) or funct3 is illegal (011/110/111 for loads, any value other than 000/001/010 for stores); mem_req SHALL never assert for that request.
REQ-025 SHALL otherwise go to ACCESS, asserting mem_req from the cycle after acceptance.
REQ-026 SHALL hold mem_req, mem_we, mem_be, mem_addr and mem_wdata stable in ACCESS until mem_ack=1 or timeout.
REQ-027 SHALL set mem_be to 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, and 1111 for word.
REQ-028 SHALL set mem_wdata to {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, and wdata for word.
REQ-029 SHALL, on mem_ack in ACCESS, capture mem_rdata, extract the addressed lane, sign-extend (LB/LH) or zero-extend (LBU/LHU), and go to RESP.
REQ-030 SHALL count ACCESS cycles with an 8-bit wait counter cleared on entry to ACCESS.
REQ-031 SHALL, if the counter reaches TIMEOUT without mem_ack, drop mem_req, go to RESP with err=1, and ignore any later mem_ack for that access.
REQ-032 SHALL give mem_ack priority over timeout when both occur in the same cycle (normal completion).
REQ-033 SHALL assert resp_valid=1 in RESP for exactly one cycle, then return to IDLE.
REQ-034 SHALL hold rdata and err valid only while resp_valid=1 and drive them to 0 otherwise.
REQ-035 SHALL give a minimum latency of 3 cycles from acceptance to resp_valid with zero-wait memory (ack in the first ACCESS cycle), and 2 cycles for error responses.
REQ-036 SHALL ignore req_valid outside IDLE; the core must hold its request until req_ready=1.

Reset
REQ-037 SHALL, while rst_n=0 at a rising clk, enter IDLE and clear all registered request fields and the counter.
REQ-038 SHALL hold all outputs at 0 during reset except req_ready, which is 0 during reset and 1 on the first cycle after reset is released.
REQ-039 SHALL, on reset during ACCESS, drop mem_req on the next edge and issue no response for the aborted request.

Verification
REQ-040 SHALL cover LB of addr=0x1003 with mem_rdata=0x80FF_FF12, ack at once -> mem_be=1000, rdata=0xFFFF_FF80, err=0, resp_valid 3 cycles after acceptance.
REQ-041 SHALL cover LHU of addr=0x2002 with mem_rdata=0xABCD_1234 -> mem_be=1100, rdata=0x0000_ABCD.
REQ-042 SHALL cover SB of addr=0x11, wdata=0x1234_5678 -> mem_addr=0x10, mem_be=0010, mem_wdata=0x7878_7878, mem_we=1, rdata=0.
REQ-043 SHALL cover LW of addr=0x6 -> err=1, resp_valid 2 cycles after acceptance, mem_req never asserted.
REQ-044 SHALL cover an SW with no mem_ack and TIMEOUT=4 -> mem_req high 4 cycles, then resp_valid with err=1; a late ack causes no second response.
REQ-045 SHALL cover rst_n=0 asserted mid-ACCESS -> mem_req=0 and resp_valid=0 after the edge, and req_ready=1 once reset is released.
